alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand and result width.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 Port: req0_ready / req1_ready  output  1  requester N granted this cycle.
REQ-006 Port: req0_op / req1_op  input  alu_ops_t  requested ALU operation.
REQ-007 Port: req0_a, req0_b / req1_a, req1_b  input  DATA_W  requester operands.
REQ-008 Port: alu_operand_a, alu_operand_b  output  DATA_W  operands driven to the shared combinational ALU.
REQ-009 Port: alu_op  output  alu_ops_t  operation driven to the shared ALU.
REQ-010 Port: alu_result  input  DATA_W  ALU result, same cycle.
REQ-011 Port: alu_zero  input  1  ALU zero flag, same cycle.
REQ-012 Port: rsp_valid  output  1  response register holds a result.
REQ-013 Port: rsp_ready  input  1  consumer accepts the response.
REQ-014 Port: rsp_id  output  1  requester index owning the response.
REQ-015 Port: rsp_result  output  DATA_W  registered ALU result.
REQ-016 Port: rsp_zero  output  1  registered zero flag.
REQ-017 Port: grant_cnt0 / grant_cnt1  output  16  saturating grant counters per requester.

Function
REQ-018 The block SHALL keep an output-register state, EMPTY or FULL, plus a 1-bit round-robin pointer last_grant.
REQ-019 The block SHALL set can_accept = (state==EMPTY) or (rsp_valid and rsp_ready).
REQ-020 If can_accept and exactly one reqN_valid is high, the block SHALL grant that requester.
REQ-021 If can_accept and both are valid, the block SHALL grant the requester not equal to last_grant, then set last_grant to the winner.
REQ-022 reqN_ready SHALL equal the grant for N; it is combinational from valids and state, and at most one is high per cycle.
REQ-023 Requesters SHALL hold op/a/b stable while valid and not ready; the block does not latch ungranted requests.
REQ-024 During a grant, alu_operand_a/b and alu_op SHALL carry the winner's fields. With no grant they SHALL be 0, 0 and ALU_ADD.
REQ-025 On a grant, at the next rising edge the block SHALL load rsp_result<=alu_result, rsp_zero<=alu_zero and rsp_id<=winner, and go to FULL. Latency is 1 cycle.
REQ-026 In FULL with rsp_ready=0, rsp_* SHALL hold unchanged, and there SHALL be no grants and no ALU activity.
REQ-027 In FULL with rsp_ready=1 and a grant, the new result SHALL replace the old and rsp_valid SHALL stay 1. Throughput is 1 op/cycle.
REQ-028 In FULL with rsp_ready=1 and no grant, the block SHALL go to EMPTY and rsp_valid SHALL be 0 next cycle.
REQ-029 rsp_valid SHALL be 1 exactly in FULL.
REQ-030 grant_cntN SHALL increment on each grant to N and saturate at 16'hFFFF.
REQ-031 rsp_valid SHALL NOT depend combinationally on rsp_ready.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL clear: state=EMPTY, last_grant=1 (req0 wins first tie), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, grant_cnt0=grant_cnt1=0.
REQ-033 While reset=1, req0_ready and req1_ready SHALL be 0 and the ALU ports SHALL drive idle values.
REQ-034 Reset asserted mid-operation SHALL discard any held response, with no rsp_valid pulse afterwards.

Verification
REQ-035 Single request: req0 ALU_ADD 10,15 with rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=25, rsp_zero=0.
REQ-036 Tie: both valid (req0 ALU_SUB 20,5; req1 ALU_AND FF00FF00,0F0F0F0F), held with rsp_ready=1 -> responses id0=15, then id1=0F000F00 on consecutive cycles; a second tie grants req0.
REQ-037 Backpressure: rsp_ready=0 while FULL, both valid for 5 cycles -> both readies 0, rsp_* stable; on rsp_ready=1 the next grant follows round-robin.
REQ-038 Zero flag: req1 ALU_SUB 7,7 -> rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-039 Reset mid-op: assert reset while FULL with rsp_ready=0 -> next cycle rsp_valid=0, counters 0; a subsequent tie grants req0.
REQ-040 Saturation: force 65537 grants to req0 -> grant_cnt0=FFFF, grant_cnt1 unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// The winner's operands are steered to the ALU in the grant cycle and the
// ALU result is captured into a single output register (EMPTY/FULL) that
// supports back-to-back operation when the consumer is ready.

package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_ops_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  alu_ops_t          req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  alu_ops_t          req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output alu_ops_t          alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic              rsp_id_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic              rsp_zero_reg;

    logic              can_accept;
    logic              grant;
    logic              winner;
    logic [1:0]        grant_vec;

    // Arbitration, ALU steering and next-state decode.
    always_comb begin
        can_accept      = 1'b0;
        grant_vec       = 2'b00;
        alu_operand_a   = '0;
        alu_operand_b   = '0;
        alu_op          = ALU_ADD;
        state_next      = state_reg;
        last_grant_next = last_grant_reg;

        // A slot opens when the register is empty or is being drained now.
        // Reset blocks all grants so the ALU ports idle during reset.
        can_accept = !reset && ((state_reg == EMPTY) || rsp_ready);

        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                // Tie: favour whoever did not win last time.
                grant_vec = last_grant_reg ? 2'b01 : 2'b10;
            end else begin
                grant_vec = {req1_valid, req0_valid};
            end
        end

        if (grant_vec[0]) begin
            alu_operand_a = req0_a;
            alu_operand_b = req0_b;
            alu_op        = req0_op;
        end else if (grant_vec[1]) begin
            alu_operand_a = req1_a;
            alu_operand_b = req1_b;
            alu_op        = req1_op;
        end

        if (grant) begin
            state_next      = FULL;
            last_grant_next = winner;
        end else if (rsp_ready) begin
            state_next = EMPTY;
        end
    end

    assign grant  = |grant_vec;
    assign winner = grant_vec[1];

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= EMPTY;
            last_grant_reg <= 1'b1;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            if (grant) begin
                rsp_id_reg     <= winner;
                rsp_result_reg <= alu_result;
                rsp_zero_reg   <= alu_zero;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            // Per-requester grant counter that sticks at all-ones.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (grant_vec[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign req0_ready = grant_vec[0];
    assign req1_ready = grant_vec[1];
    assign rsp_valid  = (state_reg == FULL);
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign grant_cnt0 = g_cnt[0].cnt_reg;
    assign grant_cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an environment ALU, a predictor that decides which
// requester should win each cycle and queues the expected response, and a
// monitor that compares the response register against the queue head.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    alu_ops_t     req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_operand_a, alu_operand_b, alu_result;
    alu_ops_t     alu_op;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [W-1:0] rsp_result;
    logic [15:0]  grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    function automatic logic [W-1:0] alu_fn(alu_ops_t op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Shared ALU seen by the DUT.
    assign alu_result = alu_fn(alu_op, alu_operand_a, alu_operand_b);
    assign alu_zero   = (alu_result == '0);

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         zero;
    } rsp_t;

    rsp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    bit   m_full = 0;
    bit   m_last = 1;
    int   m_cnt[2] = '{0, 0};
    bit   p_grant = 0;
    bit   p_winner = 0;
    rsp_t p_rsp;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: who must win this cycle, what the ALU must see.
    always @(negedge clk) begin
        bit ca, g0, g1;
        ca = !reset && (!m_full || rsp_ready);
        g0 = 0;
        g1 = 0;
        if (ca) begin
            if (req0_valid && req1_valid) begin
                if (m_last) g0 = 1; else g1 = 1;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        if (g0) begin
            check("alu_op", alu_op, req0_op);
            check("alu_a", alu_operand_a, req0_a);
            check("alu_b", alu_operand_b, req0_b);
            p_rsp = '{1'b0, alu_fn(req0_op, req0_a, req0_b), alu_fn(req0_op, req0_a, req0_b) == 0};
        end else if (g1) begin
            check("alu_op", alu_op, req1_op);
            check("alu_a", alu_operand_a, req1_a);
            check("alu_b", alu_operand_b, req1_b);
            p_rsp = '{1'b1, alu_fn(req1_op, req1_a, req1_b), alu_fn(req1_op, req1_a, req1_b) == 0};
        end else begin
            check("alu_idle_op", alu_op, ALU_ADD);
            check("alu_idle_a", alu_operand_a, 0);
            check("alu_idle_b", alu_operand_b, 0);
        end
        check("grant_cnt0", grant_cnt0, m_cnt[0]);
        check("grant_cnt1", grant_cnt1, m_cnt[1]);
        p_grant  = g0 | g1;
        p_winner = g1;
    end

    // Model update at the clock edge; enqueue the expected response.
    always @(posedge clk) begin
        if (reset) begin
            m_full = 0;
            m_last = 1;
            m_cnt  = '{0, 0};
            exp_q.delete();
        end else if (p_grant) begin
            exp_q.push_back(p_rsp);
            m_last = p_winner;
            if (m_cnt[p_winner] < 65535) m_cnt[p_winner]++;
            m_full = 1;
        end else if (rsp_ready) begin
            m_full = 0;
        end
    end

    // Monitor: response register against the queue head; pop on consume.
    always @(negedge clk) begin
        check("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (rsp_valid && exp_q.size() != 0) begin
            check("rsp_id", rsp_id, exp_q[0].id);
            check("rsp_result", rsp_result, exp_q[0].res);
            check("rsp_zero", rsp_zero, exp_q[0].zero);
            if (rsp_ready) void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1;
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic expect_rsp(string name, logic id, logic [W-1:0] res, logic zero);
        @(negedge clk);
        check({name, "_valid"}, rsp_valid, 1);
        check({name, "_id"}, rsp_id, id);
        check({name, "_res"}, rsp_result, res);
        check({name, "_zero"}, rsp_zero, zero);
    endtask

    task automatic drive_random(int n);
        for (int i = 0; i < n; i++) begin
            bit g0, g1;
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            tick();
            if (!req0_valid || g0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_op    = alu_ops_t'($urandom_range(0, 4));
                req0_a     = $urandom;
                req0_b     = ($urandom_range(0, 5) == 0) ? req0_a : $urandom;
            end
            if (!req1_valid || g1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_op    = alu_ops_t'($urandom_range(0, 4));
                req1_a     = $urandom;
                req1_b     = ($urandom_range(0, 5) == 0) ? req1_a : $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        req0_op = ALU_ADD; req0_a = 0; req0_b = 0;
        req1_op = ALU_ADD; req1_a = 0; req1_b = 0;
        apply_reset();

        // Reset state of the response register
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_zero", rsp_zero, 0);
        tick();

        // Single request
        req0_valid = 1; req0_op = ALU_ADD; req0_a = 10; req0_b = 15;
        rsp_ready = 1;
        @(negedge clk);
        check("single_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        expect_rsp("single", 0, 25, 0);
        tick();

        // Tie, held for three cycles
        apply_reset();
        req0_valid = 1; req0_op = ALU_SUB; req0_a = 20; req0_b = 5;
        req1_valid = 1; req1_op = ALU_AND; req1_a = 32'hFF00FF00; req1_b = 32'h0F0F0F0F;
        rsp_ready = 1;
        @(negedge clk);
        check("tie1_ready0", req0_ready, 1);
        tick();
        expect_rsp("tie1", 0, 15, 0);
        check("tie2_ready1", req1_ready, 1);
        tick();
        expect_rsp("tie2", 1, 32'h0F000F00, 0);
        check("tie3_ready0", req0_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        expect_rsp("tie3", 0, 15, 0);
        tick();

        // Backpressure
        apply_reset();
        req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 2;
        rsp_ready = 0;
        tick();
        req0_op = ALU_ADD; req0_a = 3; req0_b = 4;
        req1_valid = 1; req1_op = ALU_XOR; req1_a = 5; req1_b = 9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
            check("bp_hold", rsp_result, 3);
            tick();
        end
        rsp_ready = 1;
        @(negedge clk);
        check("bp_rr_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        expect_rsp("bp_rr", 1, 12, 0);
        tick();
        req0_valid = 0;
        tick();

        // Zero flag
        apply_reset();
        req1_valid = 1; req1_op = ALU_SUB; req1_a = 7; req1_b = 7;
        rsp_ready = 1;
        tick();
        req1_valid = 0;
        expect_rsp("zero", 1, 0, 1);
        tick();

        // Reset mid-operation
        apply_reset();
        req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 1;
        rsp_ready = 0;
        tick();
        req0_valid = 0;
        reset = 1;
        tick();
        @(negedge clk);
        check("midrst_valid", rsp_valid, 0);
        check("midrst_cnt0", grant_cnt0, 0);
        tick();
        reset = 0;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        @(negedge clk);
        check("midrst_tie_ready0", req0_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();

        // Random traffic
        apply_reset();
        drive_random(3000);
        tick();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (3) tick();

        // Counter saturation
        apply_reset();
        req0_valid = 1; req0_op = ALU_OR; req0_a = 32'h1234; req0_b = 32'h8000;
        rsp_ready = 1;
        repeat (65537) tick();
        req0_valid = 0;
        @(negedge clk);
        check("sat_cnt0", grant_cnt0, 16'hFFFF);
        check("sat_cnt1", grant_cnt1, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
